ps2_scancode_sequencer: RTL and testbench

Controller between `ps2_controller` and `data_control`. It consumes raw PS/2 bytes, runs the scancode-set-2 prefix state machine, and discards the following:
- break sequences
- extended keys
- keyboard status bytes
- typematic repeats

Accepted make codes are buffered in a FIFO and released to the Morse encoder over a valid/ready handshake. This lets the encoder finish a character before it takes the next one.

---
 rtl/ps2_seq_pkg.sv | 31 +++
 rtl/scancode_fifo.sv | 79 +++++++
 rtl/ps2_scancode_sequencer.sv | 125 ++++++++++++
 tb/tb_ps2_scancode_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_seq_pkg.sv
// rtl/ps2_seq_pkg.sv - shared scancode-set-2 constants and sequencer state encoding
//
// Purpose: one place for the prefix bytes, the keyboard status byte set and
// the prefix FSM encoding. data_control imports the same SC_EXT/SC_BRK values.
// Ports: none (package).
package ps2_seq_pkg;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;

  // Keyboard status / protocol bytes that never carry a key.
  localparam logic [7:0] SC_ERR0      = 8'h00;
  localparam logic [7:0] SC_BAT_OK    = 8'hAA;
  localparam logic [7:0] SC_ECHO      = 8'hEE;
  localparam logic [7:0] SC_ACK       = 8'hFA;
  localparam logic [7:0] SC_RESEND    = 8'hFE;
  localparam logic [7:0] SC_ERR1      = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } seq_state_e;

  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_BAT_OK) || (b == SC_ECHO) ||
           (b == SC_ACK)  || (b == SC_RESEND) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/scancode_fifo.sv
// rtl/scancode_fifo.sv - first-word-fall-through FIFO for accepted make codes
//
// Purpose: buffers make codes between the prefix sequencer and the encoder.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          write push_data_i this cycle
//   push_data_i     data to write
//   pop_i           consumer takes head this cycle (ignored while empty)
//   head_o          current head, zero while empty
//   valid_o         FIFO non-empty
//   count_o         occupancy, 0..DEPTH
//   drop_o          push refused this cycle (full with no simultaneous pop)
module scancode_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// rtl/ps2_scancode_sequencer.sv - PS/2 set-2 prefix sequencer with typematic filter and make-code FIFO
//
// Purpose: turns raw PS/2 bytes into a stream of new key presses, dropping
// break sequences, extended keys, status bytes and auto-repeats.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ps2_received_data        byte from the PS/2 receiver
//   ps2_received_data_strb   one-cycle strobe, byte valid
//   code_out                 FIFO head make code (0x00 when empty)
//   code_valid               FIFO non-empty
//   code_ready               downstream takes the head this cycle
//   fifo_count               FIFO occupancy
//   overflow_strb            one-cycle pulse, make code lost to a full FIFO
module ps2_scancode_sequencer
  import ps2_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    ps2_received_data,
  input  logic                          ps2_received_data_strb,
  output logic [7:0]                    code_out,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_strb
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    held_code_q, held_code_d;
  logic          held_valid_q, held_valid_d;
  logic          overflow_q;
  logic          candidate;
  logic          push;
  logic          fifo_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      held_code_q  <= '0;
      held_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      held_code_q  <= held_code_d;
      held_valid_q <= held_valid_d;
      overflow_q   <= fifo_drop;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    held_code_d  = held_code_q;
    held_valid_d = held_valid_q;
    candidate    = 1'b0;
    push         = 1'b0;

    if (ps2_received_data_strb) begin
      // A strobe always restarts the timeout, even when it lands on the
      // cycle the timer would have expired.
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2_received_data == SC_EXT)      state_d = ST_EXT;
          else if (ps2_received_data == SC_BRK) state_d = ST_BRK;
          else if (!is_status(ps2_received_data)) candidate = 1'b1;
        end
        ST_EXT: begin
          if (ps2_received_data == SC_BRK)      state_d = ST_EXT_BRK;
          else if (ps2_received_data != SC_EXT) state_d = ST_IDLE;
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          // Releasing the held key re-arms it so the next press counts.
          if (held_valid_q && (ps2_received_data == held_code_q))
            held_valid_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (timer_q == TIMER_MAX) begin
        state_d = ST_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = '0;
    end

    // Typematic repeat of the key still held down is not a new press.
    if (candidate && !(held_valid_q && (ps2_received_data == held_code_q))) begin
      push         = 1'b1;
      held_code_d  = ps2_received_data;
      held_valid_d = 1'b1;
    end
  end

  scancode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (ps2_received_data),
    .pop_i       (code_ready),
    .head_o      (code_out),
    .valid_o     (code_valid),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  assign overflow_strb = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb/tb_ps2_scancode_sequencer.sv - scoreboard bench for ps2_scancode_sequencer
module tb_ps2_scancode_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] fifo_count;
  logic       overflow_strb;

  int errors;
  int checks;
  logic [7:0] exp_q[$];

  ps2_scancode_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .code_out               (code_out),
    .code_valid             (code_valid),
    .code_ready             (code_ready),
    .fifo_count             (fifo_count),
    .overflow_strb          (overflow_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n && code_valid && code_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no output", code_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (code_out !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", code_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit exp_push);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    if (exp_push) exp_q.push_back(b);
    tick();
    ps2_received_data_strb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    code_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    code_ready = 1'b1;
    n = 0;
    while (code_valid && n < 50) begin
      tick();
      n++;
    end
    code_ready = 1'b0;
    check({name, "_drained_valid"}, code_valid, 0);
    check({name, "_drained_count"}, fifo_count, 0);
    check({name, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] codes [9];
    errors = 0;
    checks = 0;
    ps2_received_data      = 8'h00;
    ps2_received_data_strb = 1'b0;
    code_ready             = 1'b0;
    rst_n                  = 1'b0;
    for (int i = 0; i < 9; i++) codes[i] = 8'h15 + 8'(i);
    tick();
    tick();

    check("reset_valid", code_valid, 0);
    check("reset_out", code_out, 8'h00);
    check("reset_count", fifo_count, 0);
    check("reset_overflow", overflow_strb, 0);
    rst_n = 1'b1;
    tick();

    // Single make code, one-cycle latency, then a single pop.
    send(8'h1C, 1);
    check("t1_valid", code_valid, 1);
    check("t1_out", code_out, 8'h1C);
    check("t1_count", fifo_count, 1);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("t1_pop_valid", code_valid, 0);
    check("t1_pop_count", fifo_count, 0);

    // Typematic repeats and break re-arm.
    do_reset();
    send(8'h1C, 1);
    send(8'h1C, 0);
    send(8'h1C, 0);
    send(8'hF0, 0);
    send(8'h1C, 0);
    send(8'h1C, 1);
    check("t2_count", fifo_count, 2);
    drain("t2");

    // Extended make/break and status bytes discarded; FSM back in IDLE.
    do_reset();
    send(8'hE0, 0);
    send(8'h75, 0);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 0);
    send(8'hAA, 0);
    send(8'hFA, 0);
    check("t3_count", fifo_count, 0);
    check("t3_valid", code_valid, 0);
    send(8'h22, 1);
    check("t3_idle_accepts", fifo_count, 1);
    drain("t3");

    // Overflow: ninth code dropped, one-cycle pulse.
    do_reset();
    for (int i = 0; i < 8; i++) send(codes[i], 1);
    check("t4_count_full", fifo_count, 8);
    check("t4_no_overflow_yet", overflow_strb, 0);
    send(codes[8], 0);
    check("t4_overflow_pulse", overflow_strb, 1);
    check("t4_count_after", fifo_count, 8);
    tick();
    check("t4_overflow_single", overflow_strb, 0);
    drain("t4");

    // Full with coincident pop: ninth code retained.
    do_reset();
    for (int i = 0; i < 8; i++) send(codes[i], 1);
    code_ready = 1'b1;
    send(codes[8], 1);
    code_ready = 1'b0;
    check("t5_count", fifo_count, 8);
    check("t5_out_head", code_out, 8'h16);
    check("t5_no_overflow", overflow_strb, 0);
    tick();
    check("t5_no_overflow_late", overflow_strb, 0);
    drain("t5");

    // Prefix timeout after TMO idle cycles abandons the break.
    do_reset();
    send(8'hF0, 0);
    for (int i = 0; i < TMO; i++) tick();
    send(8'h1C, 1);
    check("t6_timeout_push", fifo_count, 1);
    drain("t6");

    // TMO-2 idle cycles: break still pending, byte consumed.
    do_reset();
    send(8'hF0, 0);
    for (int i = 0; i < TMO - 2; i++) tick();
    send(8'h1C, 0);
    check("t7_discard", fifo_count, 0);
    send(8'h1C, 1);
    check("t7_then_push", fifo_count, 1);
    drain("t7");

    // Asynchronous reset mid-cycle with entries queued and state EXT.
    do_reset();
    send(8'h11, 1);
    send(8'h12, 1);
    send(8'h13, 1);
    send(8'hE0, 0);
    check("t8_pre_count", fifo_count, 3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t8_async_valid", code_valid, 0);
    check("t8_async_out", code_out, 8'h00);
    check("t8_async_count", fifo_count, 0);
    check("t8_async_overflow", overflow_strb, 0);
    #2;
    rst_n = 1'b1;
    tick();
    send(8'h1C, 1);
    check("t8_after_count", fifo_count, 1);
    check("t8_after_out", code_out, 8'h1C);
    drain("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
